indirect_memory: RTL and testbench

- Parametrised single-port data memory with one clock.
- Supports three addressing modes: direct, indirect, and indirect with pointer post-increment.
- A req/ready/valid handshake sequences the multi-cycle indirect accesses.
- Sits between the CPU control unit and the unified program/data store, replacing the combinational-read, write-strobe-edge memory of the current generation.

---
 rtl/indirect_memory.sv | 158 +++++++++++++++
 tb/tb_indirect_memory.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/indirect_memory.sv
// Single-port data memory with direct, indirect and indirect post-increment addressing.
// Define MEM_AUTOINC_EN to build the pointer write-back (INC) state for mode 10.
module indirect_memory #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        addr_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              ready
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StAcc, StInc} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              wr_q, wr_d;
  logic              valid_q, valid_d;
`ifdef MEM_AUTOINC_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_q, inc_d;
  logic [ADDR_W-1:0] ptr_inc;
`endif

  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              is_ind;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // One read port: the pointer during ACC, the request address otherwise.
  assign raddr  = (state_q == StAcc) ? ptr_q : addr;
  assign rdata  = in_range(raddr) ? mem[raddr[IdxW-1:0]] : '0;
  assign is_ind = (addr_mode == 2'b01) || (addr_mode == 2'b10);
`ifdef MEM_AUTOINC_EN
  assign ptr_inc = ptr_q + ADDR_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      wr_q       <= 1'b0;
      valid_q    <= 1'b0;
`ifdef MEM_AUTOINC_EN
      addr_q     <= '0;
      inc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
`ifdef MEM_AUTOINC_EN
      addr_q     <= addr_d;
      inc_q      <= inc_d;
`endif
    end
  end

  // Array is deliberately not reset; out-of-range writes are dropped here.
  always_ff @(posedge clk) begin
    if (mem_wr_req && in_range(mem_waddr)) begin
      mem[mem_waddr[IdxW-1:0]] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    wr_d       = wr_q;
    valid_d    = 1'b0;
    mem_wr_req = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;
`ifdef MEM_AUTOINC_EN
    addr_d     = addr_q;
    inc_d      = inc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d    = wr;
          wdata_d = data_in;
`ifdef MEM_AUTOINC_EN
          addr_d  = addr;
          inc_d   = (addr_mode == 2'b10);
`endif
          if (is_ind) begin
            ptr_d   = rdata[ADDR_W-1:0];
            state_d = StAcc;
          end else begin
            valid_d = 1'b1;
            if (wr) begin
              mem_wr_req = 1'b1;
            end else begin
              data_out_d = rdata;
            end
          end
        end
      end
      StAcc: begin
        valid_d   = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = wdata_q;
        if (wr_q) begin
          mem_wr_req = 1'b1;
        end else begin
          data_out_d = rdata;
        end
`ifdef MEM_AUTOINC_EN
        state_d = inc_q ? StInc : StIdle;
`else
        state_d = StIdle;
`endif
      end
`ifdef MEM_AUTOINC_EN
      StInc: begin
        mem_wr_req = 1'b1;
        mem_waddr  = addr_q;
        mem_wdata  = DATA_W'(ptr_inc);
        state_d    = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready    = (state_q == StIdle);
    data_out = data_out_q;
    valid    = valid_q;
  end

endmodule

// File: tb/tb_indirect_memory.sv
// Self-checking bench for indirect_memory: scoreboard of expected completions plus a
// bench-side memory model; a second instance with DEPTH=512 covers out-of-range behaviour.
module tb_indirect_memory;

`ifdef MEM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic        clk, rst, req, wr;
  logic [1:0]  addr_mode;
  logic [9:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out, data_out_s;
  logic        valid, ready, valid_s, ready_s;

  logic [15:0] model_mem [1024];
  exp_t        sb [$];
  exp_t        sb_s [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  indirect_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_mode(addr_mode), .addr(addr),
    .data_in(data_in), .data_out(data_out), .valid(valid), .ready(ready)
  );

  indirect_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(512)) dut_small (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_mode(addr_mode), .addr(addr),
    .data_in(data_in), .data_out(data_out_s), .valid(valid_s), .ready(ready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req = 1'b0; wr = 1'b0; addr_mode = 2'b00; addr = '0; data_in = '0;
  endtask

  task automatic drive(input logic w, input logic [1:0] m, input logic [9:0] a,
                       input logic [15:0] d);
    req = 1'b1; wr = w; addr_mode = m; addr = a; data_in = d;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    drive(1'b1, 2'b00, a, d);
    model_mem[a] = d;
    step();
    idle_in();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    step();
    step();
    n_checks++;
    if (data_out !== 16'h0) $display("FAIL reset_data_out: got %h expected 0000", data_out);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
    else n_pass++;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_direct();
    exp_t e;
    drive(1'b1, 2'b00, 10'h190, 16'hBEEF);
    model_mem[10'h190] = 16'hBEEF;
    sb.push_back('{rd: 1'b0, data: 16'h0});
    step();
    n_checks++;
    if (valid !== 1'b1 || ready !== 1'b1)
      $display("FAIL direct_wr_handshake: got valid=%b ready=%b expected valid=1 ready=1",
               valid, ready);
    else n_pass++;
    if (valid === 1'b1 && sb.size() != 0) e = sb.pop_front();
    drive(1'b0, 2'b00, 10'h190, 16'h0);
    sb.push_back('{rd: 1'b1, data: model_mem[10'h190]});
    step();
    n_checks++;
    if (valid !== 1'b1 || ready !== 1'b1)
      $display("FAIL direct_rd_handshake: got valid=%b ready=%b expected valid=1 ready=1",
               valid, ready);
    else n_pass++;
    if (valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (data_out !== e.data) $display("FAIL direct_rd_data: got %h expected %h", data_out, e.data);
      else n_pass++;
    end
    idle_in();
    step();
    n_checks++;
    if (valid !== 1'b0) $display("FAIL direct_valid_pulse: got %b expected 0", valid);
    else n_pass++;
  endtask

  task automatic test_indirect_read();
    exp_t e;
    preload(10'h005, 16'h0200);
    preload(10'h200, 16'h1234);
    drive(1'b0, 2'b01, 10'h005, 16'h0);
    sb.push_back('{rd: 1'b1, data: model_mem[model_mem[10'h005][9:0]]});
    step();
    idle_in();
    n_checks++;
    if (ready !== 1'b0 || valid !== 1'b0)
      $display("FAIL ind_busy: got ready=%b valid=%b expected ready=0 valid=0", ready, valid);
    else n_pass++;
    step();
    n_checks++;
    if (ready !== 1'b1 || valid !== 1'b1)
      $display("FAIL ind_done: got ready=%b valid=%b expected ready=1 valid=1", ready, valid);
    else n_pass++;
    if (valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (data_out !== e.data) $display("FAIL ind_rd_data: got %h expected %h", data_out, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_autoinc_stream();
    exp_t        e;
    logic [9:0]  p;
    logic [15:0] wd [3];
    logic [9:0]  rb [4];
    logic        exp_rdy;
    wd = '{16'h000A, 16'h000B, 16'h000C};
    rb = '{10'h3FF, 10'h000, 10'h001, 10'h010};
    exp_rdy = !AutoInc;
    preload(10'h010, 16'h03FF);
    preload(10'h000, 16'h1111);
    preload(10'h001, 16'h2222);
    preload(10'h3FF, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      p = model_mem[10'h010][9:0];
      drive(1'b1, 2'b10, 10'h010, wd[i]);
      sb.push_back('{rd: 1'b0, data: 16'h0});
      model_mem[p] = wd[i];
      if (AutoInc) model_mem[10'h010] = {6'b0, p + 10'd1};
      step();
      idle_in();
      n_checks++;
      if (ready !== 1'b0 || valid !== 1'b0)
        $display("FAIL inc_accept[%0d]: got ready=%b valid=%b expected 0 0", i, ready, valid);
      else n_pass++;
      step();
      n_checks++;
      if (valid !== 1'b1 || ready !== exp_rdy)
        $display("FAIL inc_acc[%0d]: got valid=%b ready=%b expected valid=1 ready=%b",
                 i, valid, ready, exp_rdy);
      else n_pass++;
      if (valid === 1'b1 && sb.size() != 0) e = sb.pop_front();
      step();
      n_checks++;
      if (valid !== 1'b0 || ready !== 1'b1)
        $display("FAIL inc_end[%0d]: got valid=%b ready=%b expected 0 1", i, valid, ready);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b00, rb[i], 16'h0);
      sb.push_back('{rd: 1'b1, data: model_mem[rb[i]]});
      step();
      n_checks++;
      if (valid !== 1'b1 || ready !== 1'b1)
        $display("FAIL inc_rb_handshake[%0d]: got valid=%b ready=%b expected 1 1", i, valid, ready);
      else n_pass++;
      if (valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (data_out !== e.data)
          $display("FAIL inc_rb_data[%h]: got %h expected %h", rb[i], data_out, e.data);
        else n_pass++;
      end
    end
    idle_in();
  endtask

  task automatic test_busy_reject();
    exp_t       e;
    int         busy = 0;
    int         nvalid = 0;
    bit         done = 1'b0;
    logic [9:0] p;
    preload(10'h030, 16'h0040);
    preload(10'h040, 16'h7777);
    preload(10'h020, 16'h4242);
    p = model_mem[10'h030][9:0];
    drive(1'b0, 2'b10, 10'h030, 16'h0);
    sb.push_back('{rd: 1'b1, data: model_mem[p]});
    if (AutoInc) model_mem[10'h030] = {6'b0, p + 10'd1};
    step();
    // Held request during the busy window must be ignored.
    drive(1'b1, 2'b00, 10'h020, 16'h9999);
    while (!done && busy < 4) begin
      if (valid === 1'b1) begin
        nvalid++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_checks++;
          if (data_out !== e.data) $display("FAIL busy_rd_data: got %h expected %h", data_out, e.data);
          else n_pass++;
        end
      end
      if (ready === 1'b1) done = 1'b1;
      else begin
        step();
        busy++;
      end
    end
    n_checks++;
    if (busy != (AutoInc ? 2 : 1))
      $display("FAIL busy_ready_low: got %0d cycles expected %0d", busy, AutoInc ? 2 : 1);
    else n_pass++;
    n_checks++;
    if (nvalid != 1) $display("FAIL busy_valid_count: got %0d expected 1", nvalid);
    else n_pass++;
    drive(1'b0, 2'b00, 10'h020, 16'h0);
    sb.push_back('{rd: 1'b1, data: model_mem[10'h020]});
    step();
    idle_in();
    n_checks++;
    if (valid !== 1'b1) $display("FAIL busy_reaccept_valid: got %b expected 1", valid);
    else n_pass++;
    if (valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (data_out !== e.data) $display("FAIL busy_untouched: got %h expected %h", data_out, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    logic [9:0] rb [2];
    rb = '{10'h050, 10'h060};
    preload(10'h050, 16'h0060);
    drive(1'b1, 2'b10, 10'h050, 16'hDEAD);
    sb.push_back('{rd: 1'b0, data: 16'h0});
    model_mem[10'h060] = 16'hDEAD;
    step();
    idle_in();
    step();
    n_checks++;
    if (valid !== 1'b1) $display("FAIL rstmid_acc_valid: got %b expected 1", valid);
    else n_pass++;
    if (valid === 1'b1 && sb.size() != 0) e = sb.pop_front();
    rst = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 16'h0 || valid !== 1'b0 || ready !== 1'b1)
      $display("FAIL rstmid_outputs: got data_out=%h valid=%b ready=%b expected 0000 0 1",
               data_out, valid, ready);
    else n_pass++;
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, rb[i], 16'h0);
      sb.push_back('{rd: 1'b1, data: model_mem[rb[i]]});
      step();
      if (valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (data_out !== e.data)
          $display("FAIL rstmid_mem[%h]: got %h expected %h", rb[i], data_out, e.data);
        else n_pass++;
      end else begin
        n_checks++;
        $display("FAIL rstmid_rd_valid[%0d]: got %b expected 1", i, valid);
      end
    end
    idle_in();
  endtask

  task automatic test_out_of_range();
    exp_t       e;
    logic [9:0] rb [2];
    rb = '{10'h300, 10'h100};
    preload(10'h100, 16'h1357);
    preload(10'h300, 16'h5555);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, rb[i], 16'h0);
      sb_s.push_back('{rd: 1'b1, data: (rb[i] < 10'd512) ? model_mem[rb[i]] : 16'h0});
      sb.push_back('{rd: 1'b1, data: model_mem[rb[i]]});
      step();
      n_checks++;
      if (valid_s !== 1'b1 || ready_s !== 1'b1)
        $display("FAIL oor_handshake[%0d]: got valid=%b ready=%b expected 1 1", i, valid_s, ready_s);
      else n_pass++;
      if (valid_s === 1'b1 && sb_s.size() != 0) begin
        e = sb_s.pop_front();
        n_checks++;
        if (data_out_s !== e.data)
          $display("FAIL oor_small[%h]: got %h expected %h", rb[i], data_out_s, e.data);
        else n_pass++;
      end
      if (valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (data_out !== e.data)
          $display("FAIL oor_full[%h]: got %h expected %h", rb[i], data_out, e.data);
        else n_pass++;
      end
    end
    idle_in();
  endtask

  task automatic test_drain();
    n_checks++;
    if (sb.size() != 0 || sb_s.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sb.size(), sb_s.size());
    else n_pass++;
  endtask

  initial begin
    idle_in();
    test_reset();
    test_direct();
    test_indirect_read();
    test_autoinc_stream();
    test_busy_reject();
    test_reset_mid();
    test_out_of_range();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
